// File: rtl/hilo_muldiv.sv
// hilo_muldiv: execute-stage producer of the HI/LO write/forward bus.
// Runs mult/multu/div/divu over several cycles and handles mthi/mtlo in one cycle.
// Parameter MUL_ITERATIVE selects a 32-cycle shift-add multiplier (1) or a
// single-cycle multiplier (0).
// Optional macro HILO_DIV0_SKIP_EN: a zero divisor finishes at once with
// hi=src1, lo=32'hFFFFFFFF instead of running the full restoring sequence.
`timescale 1ns/1ps

module hilo_muldiv #(
    parameter int MUL_ITERATIVE = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        op_mult,
    input  logic        op_multu,
    input  logic        op_div,
    input  logic        op_divu,
    input  logic        op_mthi,
    input  logic        op_mtlo,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output logic        stallreq,
    output logic        busy,
    output logic [65:0] hilo_bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;

    // Shared accumulator: {hi, lo} for multiply, {remainder, quotient} for divide
    logic [63:0] r_acc;
    // Multiplicand magnitude for multiply, divisor magnitude for divide
    logic [31:0] r_opB;
    logic [5:0]  r_cnt;
    logic        r_isDiv;
    logic        r_resSign;
    logic        r_remSign;

    logic        w_startMul;
    logic        w_startDiv;
    logic        w_signedOp;
    logic        w_start;
    logic        w_div0Skip;
    logic [31:0] w_absA;
    logic [31:0] w_absB;
    logic [63:0] w_fastProd;
    logic [32:0] w_mulSum;
    logic [32:0] w_divShift;
    logic        w_divFits;
    logic [31:0] w_divRem;
    logic [63:0] w_prod;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [63:0] w_result;

    assign w_startMul = op_mult | op_multu;
    assign w_startDiv = op_div | op_divu;
    assign w_signedOp = op_mult | op_div;
    assign w_start    = (r_state == S_IDLE) && !flush && (w_startMul || w_startDiv);

    // Signed operations work on magnitudes; 0x80000000 stays 0x80000000 as an unsigned magnitude
    assign w_absA = (w_signedOp && src1[31]) ? (32'd0 - src1) : src1;
    assign w_absB = (w_signedOp && src2[31]) ? (32'd0 - src2) : src2;

`ifdef HILO_DIV0_SKIP_EN
    assign w_div0Skip = w_startDiv && (src2 == 32'd0);
`else
    assign w_div0Skip = 1'b0;
`endif

    assign w_fastProd = {32'd0, w_absA} * {32'd0, w_absB};

    // Shift-add step: multiplier sits in the low half and is consumed LSB first
    assign w_mulSum = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opB} : 33'd0);

    // Restoring step: shift next dividend bit into the partial remainder and try to subtract
    assign w_divShift = {r_acc[63:32], r_acc[31]};
    assign w_divFits  = (w_divShift >= {1'b0, r_opB});
    assign w_divRem   = w_divShift[31:0] - r_opB;

    // Sign fixup applied on the way out in DONE
    assign w_prod   = r_resSign ? (64'd0 - r_acc) : r_acc;
    assign w_quot   = r_resSign ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
    assign w_rem    = r_remSign ? (32'd0 - r_acc[63:32]) : r_acc[63:32];
    assign w_result = r_isDiv ? {w_rem, w_quot} : w_prod;

    assign busy = (r_state != S_IDLE);

    // State register; reset or flush always lands in IDLE
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state, stall request and HI/LO bus; mthi/mtlo and DONE are the only writers
    always_comb begin
        w_next   = r_state;
        stallreq = 1'b0;
        hilo_bus = 66'd0;
        case (r_state)
            S_IDLE: begin
                if (!flush) begin
                    if (op_mthi) begin
                        hilo_bus = {2'b10, src1, 32'd0};
                    end else if (op_mtlo) begin
                        hilo_bus = {2'b01, 32'd0, src1};
                    end else if (w_startMul) begin
                        stallreq = 1'b1;
                        w_next   = (MUL_ITERATIVE == 0) ? S_DONE : S_MUL;
                    end else if (w_startDiv) begin
                        stallreq = 1'b1;
                        w_next   = w_div0Skip ? S_DONE : S_DIV;
                    end
                end
            end
            S_MUL: begin
                stallreq = 1'b1;
                if (r_cnt == 6'd31) begin
                    w_next = S_DONE;
                end
            end
            S_DIV: begin
                stallreq = 1'b1;
                if (r_cnt == 6'd31) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (!flush) begin
                    hilo_bus = {2'b11, w_result};
                end
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        if (flush) begin
            w_next = S_IDLE;
        end
        if (!resetn) begin
            stallreq = 1'b0;
            hilo_bus = 66'd0;
        end
    end

    // Datapath: operand capture at start, one multiply or divide iteration per busy cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_acc     <= 64'd0;
            r_opB     <= 32'd0;
            r_cnt     <= 6'd0;
            r_isDiv   <= 1'b0;
            r_resSign <= 1'b0;
            r_remSign <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_cnt     <= 6'd0;
                        r_isDiv   <= w_startDiv;
                        r_resSign <= w_signedOp & (src1[31] ^ src2[31]);
                        r_remSign <= w_signedOp & src1[31];
                        if (w_startMul) begin
                            r_opB <= w_absA;
                            r_acc <= (MUL_ITERATIVE == 0) ? w_fastProd : {32'd0, w_absB};
                        end else if (w_div0Skip) begin
                            r_opB     <= 32'd0;
                            r_acc     <= {src1, 32'hFFFF_FFFF};
                            r_resSign <= 1'b0;
                            r_remSign <= 1'b0;
                        end else begin
                            r_opB <= w_absB;
                            r_acc <= {32'd0, w_absA};
                        end
                    end
                end
                S_MUL: begin
                    r_acc <= {w_mulSum, r_acc[31:1]};
                    r_cnt <= r_cnt + 6'd1;
                end
                S_DIV: begin
                    r_acc <= {(w_divFits ? w_divRem : w_divShift[31:0]), r_acc[30:0], w_divFits};
                    r_cnt <= r_cnt + 6'd1;
                end
                default: begin
                    r_cnt <= 6'd0;
                end
            endcase
        end
    end

endmodule

// File: doc/hilo_muldiv.md
Name: hilo_muldiv

Overview:
- Execute-stage producer for the HI/LO special registers.
- Runs mult/multu/div/divu over multiple cycles and handles mthi/mtlo in a single cycle.
- Stalls the pipeline while it is busy.
- Emits the 66-bit HI/LO write/forward bus {hi_we, lo_we, hi[31:0], lo[31:0]}. That bus feeds the register file's HI/LO write ports and its EX-stage HI/LO forwarding input.

Parameters:
MUL_ITERATIVE, 1, 1 = radix-2 shift-add multiply over 32 cycles; 0 = single-cycle multiply (DONE on the next cycle)

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
flush  in  1  abort any in-flight operation; no write
op_mult  in  1  signed multiply start (single-cycle pulse, IDLE only)
op_multu  in  1  unsigned multiply start
op_div  in  1  signed divide start
op_divu  in  1  unsigned divide start
op_mthi  in  1  write src1 to HI
op_mtlo  in  1  write src1 to LO
src1  in  32  rs operand / dividend / multiplicand
src2  in  32  rt operand / divisor / multiplier
stallreq  out  1  hold IF/ID/EX
busy  out  1  FSM not IDLE
hilo_bus  out  66  {hi_we[65], lo_we[64], hi[63:32], lo[31:0]}

Behaviour:
- Reset: FSM=IDLE; all internal registers cleared; stallreq=0, busy=0, hilo_bus=66'b0.
- At most one op_* is high per cycle; more than one is illegal and has undefined behaviour.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - op_mthi/op_mtlo produce a combinational same-cycle bus: {1,0,src1,32'b0} for mthi, {0,1,32'b0,src1} for mtlo.
  - No stall, no state change.
  - Any mult/div op latches operands, asserts stallreq combinationally in that same cycle, and moves to MUL or DIV.
- Operand prep at start:
  - Signed ops store absolute values plus a result-sign bit (s1^s2) and a remainder-sign bit (s1).
  - Unsigned ops store the raw operands.
- MUL (MUL_ITERATIVE=1):
  - 64-bit accumulator; 6-bit counter counts 0..31, one multiplier bit per cycle.
  - Moves to DONE after the 32nd iteration.
  - With MUL_ITERATIVE=0, MUL is skipped and the product is computed in the start cycle, going straight to DONE.
- DIV:
  - Restoring division, one quotient bit per cycle, 32 cycles, then DONE.
- DONE:
  - Applies sign fixup: negate the 64-bit product; negate the quotient if result-sign; negate the remainder if remainder-sign.
  - Drives hilo_bus with hi_we=lo_we=1 and HI/LO = {product[63:32], product[31:0]} or {remainder, quotient}.
  - stallreq=0; the held instruction retires this cycle.
  - Returns to IDLE next cycle.
- Latency (iterative): start at cycle T, stallreq high T..T+32, DONE/write at T+33. Stall length is 1 cycle when MUL_ITERATIVE=0 for mult.
- busy is high in MUL, DIV and DONE.
- op_* pulses outside IDLE are ignored; the pipeline is stalled, so none are legal there.
- flush:
  - Any state goes to IDLE on the next edge; no write is produced.
  - If flush coincides with DONE, the write is suppressed (hi_we=lo_we=0).
  - flush in IDLE suppresses same-cycle mthi/mtlo writes and blocks any start.
- Reset mid-operation: immediate IDLE, outputs cleared, no partial write.
- Width rules: multiply is 32x32 to 64. Division wrap-around: div 0x80000000/0xFFFFFFFF yields lo=0x80000000, hi=0 (two's-complement wrap, no trap).
- Divide by zero without the macro:
  - Full 32 iterations; restoring result on magnitudes is quotient all-ones, remainder = |dividend|.
  - Sign fixup is then applied; the result is deterministic but architecturally unpredictable.

Optional Feature:
- Macro: HILO_DIV0_SKIP_EN.
- Defined: a divisor of zero at start goes directly to DONE (one stall cycle) with hi=src1, lo=32'hFFFFFFFF for both div and divu.
- Undefined: no zero check; divide by zero runs the full 32 cycles with the fixed-up restoring result above.

Test Plan:
- multu 0xFFFFFFFF x 0xFFFFFFFF -> stallreq high 33 cycles, then one cycle of hilo_bus={1,1,0xFFFFFFFE,0x00000001}, busy low after.
- mult 0xFFFFFFFD (-3) x 5 -> DONE bus hi=0xFFFFFFFF, lo=0xFFFFFFF1; repeat with MUL_ITERATIVE=0 -> write one cycle after start.
- div -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu 7/2 -> lo=3, hi=1; div 0x80000000/-1 -> lo=0x80000000, hi=0.
- mthi src1=0x12345678 in IDLE -> same cycle hilo_bus={1,0,0x12345678,0}, stallreq=0; mtlo 0xCAFEF00D -> {0,1,0,0xCAFEF00D}.
- divu start, flush at cycle 10 -> IDLE next edge, stallreq/busy 0, no write ever; resetn low at cycle 20 of a mult -> outputs 0 immediately.
- divu 5/0: with HILO_DIV0_SKIP_EN -> one stall cycle then hi=5, lo=0xFFFFFFFF; without -> 33-cycle stall, then hi=5, lo=0xFFFFFFFF.
